// File: rtl/fetch_stage_pkg.sv
// Shared constants for the JARVIS RV32I front end: canonical NOP, default reset vector
// and the 2-bit fetch FSM state encodings.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/ifid_pipeline_reg.sv
// Pipeline register between two stages. Priority: kill beats stall beats load, else bubble.
// The pc fields keep their last value whenever no new instruction is loaded.
module ifid_pipeline_reg
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            stall,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (kill || (!stall && !load_valid)) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (!stall) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time over a valid/ready
// channel, buffers a response that arrives during a stall, and feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic            fetch_fault
);

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic            drop_pending;

    logic            req_fire;
    logic [XLEN-1:0] redirect_target;
    logic            load_valid;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] load_pc;

    // Gating with rst_n keeps the request low for the whole reset, not just after the first edge.
    assign imem_req_valid  = rst_n && (state == ST_REQ);
    assign imem_req_addr   = pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_REQ;
            pc           <= RESET_PC;
            req_pc       <= '0;
            hold_instr   <= '0;
            hold_pc      <= '0;
            drop_pending <= 1'b0;
            fetch_fault  <= 1'b0;
        end else begin
            fetch_fault <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= ST_WAIT;
                    end
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        if (req_fire) drop_pending <= 1'b1;
                    end else if (req_fire) begin
                        pc <= pc + XLEN'(4);
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        // A reply landing with the redirect is the stale one: drop it now,
                        // otherwise drop_pending would wait for a reply that never comes.
                        if (imem_resp_valid) begin
                            drop_pending <= 1'b0;
                            state        <= ST_REQ;
                        end else begin
                            drop_pending <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop_pending) begin
                            drop_pending <= 1'b0;
                            state        <= ST_REQ;
                        end else if (!stall) begin
                            state <= ST_REQ;
                        end else begin
                            hold_instr <= imem_resp_data;
                            hold_pc    <= req_pc;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= ST_REQ;
                    end else if (!stall) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        load_valid = 1'b0;
        load_instr = imem_resp_data;
        load_pc    = req_pc;
        case (state)
            ST_WAIT: load_valid = imem_resp_valid && !drop_pending;
            ST_HOLD: begin
                load_valid = 1'b1;
                load_instr = hold_instr;
                load_pc    = hold_pc;
            end
            default: load_valid = 1'b0;
        endcase
    end

    ifid_pipeline_reg #(
        .XLEN(XLEN)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .kill       (redirect_valid || flush),
        .stall      (stall),
        .load_valid (load_valid),
        .load_instr (load_instr),
        .load_pc    (load_pc),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc         (ifid_pc),
        .pc_plus4   (ifid_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, reset corner cases, then randomized traffic
// checked against a program-order model of fetch addresses and delivered instructions.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] KEY = 32'hAAAA_0000;
    localparam int          NV  = 38;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .fetch_fault     (fetch_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall, flush, redir;
        logic [31:0] redir_pc;
        logic        ready, resp;
        logic [31:0] resp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                                input logic rdy, input logic rsp, input logic [31:0] rsp_pc,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] epc, input logic ef);
        vec_t v;
        v.stall = s;  v.flush = f;  v.redir = r;  v.redir_pc = rpc;
        v.ready = rdy; v.resp = rsp; v.resp_pc = rsp_pc;
        v.exp_req = er; v.exp_addr = ea;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_fault = ef;
        return v;
    endfunction

    vec_t vec [NV];

    // Randomized-phase model state
    logic [31:0] exp_next, exp_fetch, mem_addr, tgt, req_addr_s;
    logic [31:0] p_instr, p_pc, p_pc4;
    logic        mem_pend, acc, p_valid;
    int          mem_delay, delivered;

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, imem_req_valid, 0);
        check({tag, " ifid_valid"}, ifid_valid, 0);
        check({tag, " ifid_instr"}, ifid_instr, NOP_INSTR);
        check({tag, " ifid_pc"}, ifid_pc, 0);
        check({tag, " ifid_pc_plus4"}, ifid_pc_plus4, 0);
        check({tag, " fetch_fault"}, fetch_fault, 0);
    endtask

    initial begin
        //              s f r rpc           rdy rsp rsp_pc       er ea            ev epc           ef
        vec[0]  = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h0,         0,32'h0,         0);
        vec[1]  = mk(0,0,0,32'h0,         0,1,32'h0,         0,32'h0,         1,32'h0,         0);
        vec[2]  = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h4,         0,32'h0,         0);
        vec[3]  = mk(0,0,0,32'h0,         0,1,32'h4,         0,32'h0,         1,32'h4,         0);
        vec[4]  = mk(1,0,0,32'h0,         1,0,32'h0,         1,32'h8,         1,32'h4,         0);
        vec[5]  = mk(1,0,0,32'h0,         0,1,32'h8,         0,32'h0,         1,32'h4,         0);
        vec[6]  = mk(1,0,0,32'h0,         0,0,32'h0,         0,32'h0,         1,32'h4,         0);
        vec[7]  = mk(1,0,0,32'h0,         0,0,32'h0,         0,32'h0,         1,32'h4,         0);
        vec[8]  = mk(0,0,0,32'h0,         0,0,32'h0,         0,32'h0,         1,32'h8,         0);
        vec[9]  = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'hC,         0,32'h0,         0);
        vec[10] = mk(0,0,0,32'h0,         0,1,32'hC,         0,32'h0,         1,32'hC,         0);
        vec[11] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h10,        0,32'h0,         0);
        vec[12] = mk(0,0,1,32'h100,       0,0,32'h0,         0,32'h0,         0,32'h0,         0);
        vec[13] = mk(0,0,0,32'h0,         0,1,32'h10,        0,32'h0,         0,32'h0,         0);
        vec[14] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h100,       0,32'h0,         0);
        vec[15] = mk(0,0,0,32'h0,         0,1,32'h100,       0,32'h0,         1,32'h100,       0);
        vec[16] = mk(0,0,1,32'h102,       0,0,32'h0,         1,32'h104,       0,32'h0,         1);
        vec[17] = mk(0,0,0,32'h0,         0,0,32'h0,         1,32'h100,       0,32'h0,         0);
        vec[18] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h100,       0,32'h0,         0);
        vec[19] = mk(0,0,0,32'h0,         0,1,32'h100,       0,32'h0,         1,32'h100,       0);
        vec[20] = mk(0,0,1,32'h200,       1,0,32'h0,         1,32'h104,       0,32'h0,         0);
        vec[21] = mk(0,0,0,32'h0,         0,1,32'h104,       0,32'h0,         0,32'h0,         0);
        vec[22] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h200,       0,32'h0,         0);
        vec[23] = mk(0,0,0,32'h0,         0,1,32'h200,       0,32'h0,         1,32'h200,       0);
        vec[24] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h204,       0,32'h0,         0);
        vec[25] = mk(1,0,0,32'h0,         0,1,32'h204,       0,32'h0,         0,32'h0,         0);
        vec[26] = mk(1,1,1,32'h40,        0,0,32'h0,         0,32'h0,         0,32'h0,         0);
        vec[27] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h40,        0,32'h0,         0);
        vec[28] = mk(0,0,0,32'h0,         0,1,32'h40,        0,32'h0,         1,32'h40,        0);
        vec[29] = mk(0,0,1,32'hFFFF_FFFC, 0,0,32'h0,         1,32'h44,        0,32'h0,         0);
        vec[30] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'hFFFF_FFFC, 0,32'h0,         0);
        vec[31] = mk(0,0,0,32'h0,         0,1,32'hFFFF_FFFC, 0,32'h0,         1,32'hFFFF_FFFC, 0);
        vec[32] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h0,         0,32'h0,         0);
        vec[33] = mk(0,0,0,32'h0,         0,1,32'h0,         0,32'h0,         1,32'h0,         0);
        vec[34] = mk(0,1,0,32'h0,         0,0,32'h0,         1,32'h4,         0,32'h0,         0);
        vec[35] = mk(0,0,0,32'h0,         0,1,32'h55,        1,32'h4,         0,32'h0,         0);
        vec[36] = mk(0,0,0,32'h0,         1,0,32'h0,         1,32'h4,         0,32'h0,         0);
        vec[37] = mk(0,0,0,32'h0,         0,1,32'h4,         0,32'h0,         1,32'h4,         0);

        stall = 0; flush = 0; redirect_valid = 0; redirect_pc = '0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs($sformatf("reset%0d", i));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cycle table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            stall           = vec[i].stall;
            flush           = vec[i].flush;
            redirect_valid  = vec[i].redir;
            redirect_pc     = vec[i].redir_pc;
            imem_req_ready  = vec[i].ready;
            imem_resp_valid = vec[i].resp;
            imem_resp_data  = vec[i].resp_pc ^ KEY;
            #1;
            check($sformatf("v%0d req_valid", i), imem_req_valid, vec[i].exp_req);
            if (vec[i].exp_req)
                check($sformatf("v%0d req_addr", i), imem_req_addr, vec[i].exp_addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d ifid_valid", i), ifid_valid, vec[i].exp_valid);
            check($sformatf("v%0d fetch_fault", i), fetch_fault, vec[i].exp_fault);
            if (vec[i].exp_valid) begin
                check($sformatf("v%0d ifid_pc", i), ifid_pc, vec[i].exp_pc);
                check($sformatf("v%0d ifid_instr", i), ifid_instr, vec[i].exp_pc ^ KEY);
                check($sformatf("v%0d ifid_pc_plus4", i), ifid_pc_plus4, vec[i].exp_pc + 32'd4);
            end else begin
                check($sformatf("v%0d ifid_nop", i), ifid_instr, NOP_INSTR);
            end
        end

        // Reset asserted mid-WAIT with a non-zero IF/ID pc, then a stale response across reset
        @(negedge clk);
        stall = 0; flush = 0; redirect_valid = 0;
        imem_req_ready = 1; imem_resp_valid = 0;
        @(posedge clk);
        #2;
        check("pre-reset ifid_pc", ifid_pc, 32'h4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait");
        @(negedge clk);
        imem_req_ready  = 0;
        imem_resp_valid = 1;
        imem_resp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("stale resp ignored", ifid_valid, 0);
        @(negedge clk);
        imem_resp_valid = 0;
        check("post-reset req_valid", imem_req_valid, 1);
        check("post-reset req_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1;
        @(negedge clk);
        imem_req_ready  = 0;
        imem_resp_valid = 1;
        imem_resp_data  = 32'h0 ^ KEY;
        @(posedge clk);
        #1;
        check("post-reset first valid", ifid_valid, 1);
        check("post-reset first pc", ifid_pc, 32'h0);

        // Randomized traffic against the program-order model
        @(negedge clk);
        imem_resp_valid = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_next  = 32'h0;
        exp_fetch = 32'h0;
        mem_pend  = 1'b0;
        mem_addr  = '0;
        mem_delay = 0;
        delivered = 0;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            tgt            = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : ($urandom & 32'h0000_0FFF);
            redirect_pc    = tgt;
            flush          = redirect_valid && ($urandom_range(0, 1) == 1);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            imem_resp_valid = mem_pend && (mem_delay == 0);
            imem_resp_data  = imem_resp_valid ? (mem_addr ^ KEY) : $urandom;
            #1;
            acc        = imem_req_valid && imem_req_ready;
            req_addr_s = imem_req_addr;
            p_valid = ifid_valid; p_instr = ifid_instr; p_pc = ifid_pc; p_pc4 = ifid_pc_plus4;
            @(posedge clk);
            #1;

            if (imem_resp_valid) mem_pend = 1'b0;
            else if (mem_pend) mem_delay--;
            if (acc) begin
                check("rnd one_outstanding", mem_pend, 0);
                check("rnd req_addr", req_addr_s, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                mem_pend  = 1'b1;
                mem_addr  = req_addr_s;
                mem_delay = $urandom_range(0, 2);
            end

            check("rnd fetch_fault", fetch_fault, redirect_valid && (tgt[1:0] != 2'b00));
            if (redirect_valid || flush) begin
                check("rnd kill valid", ifid_valid, 0);
                check("rnd kill instr", ifid_instr, NOP_INSTR);
            end else if (stall) begin
                check("rnd stall valid", ifid_valid, p_valid);
                check("rnd stall instr", ifid_instr, p_instr);
                check("rnd stall pc", ifid_pc, p_pc);
                check("rnd stall pc_plus4", ifid_pc_plus4, p_pc4);
            end else if (ifid_valid) begin
                check("rnd deliver pc", ifid_pc, exp_next);
                check("rnd deliver instr", ifid_instr, exp_next ^ KEY);
                check("rnd deliver pc_plus4", ifid_pc_plus4, exp_next + 32'd4);
                exp_next = exp_next + 32'd4;
                delivered++;
            end else begin
                check("rnd bubble instr", ifid_instr, NOP_INSTR);
            end

            if (redirect_valid) begin
                exp_fetch = tgt & ~32'd3;
                exp_next  = tgt & ~32'd3;
            end
        end
        check("rnd progress", (delivered >= 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the JARVIS RV32I pipeline.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response.
- Drives the IF/ID pipeline register that feeds decode_control_unit and the register-file read.
- Accepts stall/flush from the hazard logic and PC redirects from execute (taken branch, JAL, JALR).

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
XLEN, 32, address/instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold IF/ID contents; fetch pauses
flush  in  1  invalidate IF/ID (insert bubble)
redirect_valid  in  1  execute requests PC change
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address of request
imem_resp_valid  in  1  response data valid
imem_resp_data  in  XLEN  fetched instruction
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  XLEN  instruction to decode
ifid_pc  out  XLEN  PC of ifid_instr
ifid_pc_plus4  out  XLEN  ifid_pc + 4 (for JAL/JALR link)
fetch_fault  out  1  one-cycle pulse: misaligned redirect target

Behaviour:
Reset (async assert, sync deassert handled upstream):
- pc=RESET_PC; state=REQ; drop_pending=0; hold buffer empty.
- ifid_valid=0, ifid_instr=NOP (32'h0000_0013), ifid_pc=0, ifid_pc_plus4=0, fetch_fault=0.
- imem_req_valid=0 while rst_n low.
- Reset mid-transaction abandons the outstanding request; any response arriving after reset is ignored until the first new request is issued.

Core rules:
- At most one outstanding request.
- Request channel is non-sticky: memory samples addr only on valid&ready; addr may change between cycles while not yet accepted.
- Throughput: 1 instruction per 2 cycles minimum (request cycle, response cycle).

FSM states REQ, WAIT, HOLD:
- REQ: imem_req_valid=1, imem_req_addr=pc. On ready: pc<=pc+4, latch req_pc=pc, go WAIT.
- WAIT: imem_req_valid=0. On resp_valid:
  - drop_pending=1: discard response, clear drop_pending, go REQ.
  - else if stall=0: load IF/ID {1, data, req_pc, req_pc+4}, go REQ.
  - else: store in hold buffer, go HOLD.
- HOLD: imem_req_valid=0. When stall=0: move buffer into IF/ID, go REQ.

IF/ID update priority each cycle (highest first):
1. redirect_valid or flush: valid<=0, instr<=NOP; pc fields hold.
2. stall: hold all fields.
3. New instruction available (WAIT response or HOLD drain): load it.
4. Otherwise: bubble (valid<=0, instr<=NOP).

Redirect:
- pc<=redirect_pc with bits [1:0] forced to 0.
- fetch_fault<=1 for one cycle if redirect_pc[1:0]!=0.
- Hold buffer is cleared.
- From WAIT: stay in WAIT, set drop_pending.
- From HOLD: go REQ.
- From REQ: a request accepted in the same cycle carried the old pc; go WAIT with drop_pending=1. If not accepted, stay REQ; the new addr is presented next cycle.
- Redirect overrides stall.
- Repeated redirects keep drop_pending=1 (single flag, no counting).

Other rules:
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- imem_resp_valid in REQ or HOLD is a protocol violation; it is ignored.

Decomposition:
- Shared constants file constants.v gains NOP_INSTR (32'h0000_0013), DEFAULT_RESET_PC, and the fetch FSM state encodings (2-bit).
- One sub-module, ifid_pipeline_reg: IF/ID register with the valid/flush/stall priority above. Reused later for ID/EX.

Test Plan:
1. rst_n low for 3 cycles, then high, imem ready/resp ideal -> first imem_req_addr=0x0. During reset: ifid_valid=0, ifid_instr=0x00000013. Reassert rst_n mid-WAIT -> all outputs return to reset values immediately.
2. Straight-line: ready=1, resp next cycle with data=addr^0xAAAA0000 -> IF/ID shows pc 0x0,0x4,0x8 every 2 cycles, pc_plus4 correct, bubbles in between.
3. stall=1 from the cycle the 0x8 response arrives, for 4 cycles -> IF/ID holds 0x4 entry, no requests issued. Stall release -> 0x8 entry appears next cycle, then request 0xC.
4. redirect_valid with redirect_pc=0x100 while WAIT for 0x8 -> response for 0x8 discarded, ifid_valid=0, next imem_req_addr=0x100, then IF/ID pc=0x100.
5. redirect_pc=0x102 -> fetch_fault high exactly one cycle, next imem_req_addr=0x100.
6. Simultaneous stall=1, flush=1, redirect_valid=1 (target 0x40) in HOLD -> hold buffer cleared, ifid_valid=0 next cycle, next request addr 0x40.
